// File: rtl/apb_write_engine_pkg.sv
// Shared types for the APB write engine: AXI response/burst codes, captured
// address-phase info and the engine state encoding.
package apb_write_engine_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef struct packed {
    logic [3:0] id;
    logic [2:0] size;
    burst_t     burst;
  } addr_info_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DRAIN,
    ST_RESP
  } eng_state_t;

  // Only FIXED/INCR bursts whose beat size fits the data bus become APB writes.
  function automatic logic burst_legal(input logic [1:0] burst, input logic [2:0] size,
                                       input int unsigned bus_bytes);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) &&
           ((32'd1 << size) <= bus_bytes);
  endfunction

endpackage

// File: rtl/apb_write_engine_if.sv
// APB requester-side bus bundle; master is the engine, slave is the completer.
interface apb_write_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [2:0]              pprot;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr
  );
endinterface

// File: rtl/apb_write_engine_sync_fifo.sv
// Small synchronous FIFO with a combinational head view, so the APB setup
// phase can present the oldest beat in the same cycle it is selected.
module apb_write_engine_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_write_engine.sv
// Turns a captured AXI write burst plus buffered W beats into one APB write per
// beat, folding every PSLVERR into a single AXI-style burst response.
module apb_write_engine
  import apb_write_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    addr_info_valid,
  input  logic [3:0]              addr_id,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [3:0]              addr_len,
  input  logic [2:0]              addr_size,
  input  logic [1:0]              addr_burst,
  input  logic                    data_valid,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] data_strb,
  output logic                    data_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [3:0]              resp_id,
  output logic [1:0]              resp,
  output logic                    busy,
  apb_write_engine_if.master      apb
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int FW = DATA_WIDTH + SW;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  eng_state_t            state_reg, state_next;
  logic                  armed_reg, armed_next;
  addr_info_t            info_reg, info_next;
  logic [ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [3:0]            beat_cnt_reg, beat_cnt_next;
  logic                  err_reg, err_next;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FW-1:0]         fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  more_beats;
  logic [ADDR_WIDTH-1:0] addr_step;
  logic                  apb_sel;
  logic                  apb_enable;
  resp_t                 resp_code;

  apb_write_engine_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({data, data_strb}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign data_ready = !fifo_full;
  assign fifo_push  = data_valid && data_ready;
  assign addr_step  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << info_reg.size;
  // A beat pushed this cycle is readable next cycle, so it also counts as "more".
  assign more_beats = (fifo_count > CW'(1)) || fifo_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      armed_reg    <= 1'b0;
      info_reg     <= '0;
      cur_addr_reg <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      armed_reg    <= armed_next;
      info_reg     <= info_next;
      cur_addr_reg <= cur_addr_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    armed_next    = armed_reg;
    info_next     = info_reg;
    cur_addr_next = cur_addr_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    fifo_pop      = 1'b0;
    apb_sel       = 1'b0;
    apb_enable    = 1'b0;
    resp_valid    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Armed: a burst is in flight but is waiting for its next beat.
        if (armed_reg) begin
          if (!fifo_empty) begin
            state_next = ST_SETUP;
            armed_next = 1'b0;
          end
        end else if (addr_info_valid) begin
          info_next     = '{id: addr_id, size: addr_size, burst: burst_t'(addr_burst)};
          cur_addr_next = addr;
          beat_cnt_next = addr_len;
          err_next      = 1'b0;
          if (burst_legal(addr_burst, addr_size, 32'(SW))) begin
            if (!fifo_empty) state_next = ST_SETUP;
            else             armed_next = 1'b1;
          end else begin
            err_next   = 1'b1;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_SETUP: begin
        apb_sel    = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = 1'b1;
        if (apb.pready) begin
          fifo_pop = 1'b1;
          err_next = err_reg | apb.pslverr;
          if (info_reg.burst == BURST_INCR) cur_addr_next = cur_addr_reg + addr_step;
          if (beat_cnt_reg == 4'd0) begin
            state_next = ST_RESP;
          end else begin
            beat_cnt_next = beat_cnt_reg - 4'd1;
            if (more_beats) begin
              state_next = ST_SETUP;
            end else begin
              state_next = ST_IDLE;
              armed_next = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (beat_cnt_reg == 4'd0) state_next = ST_RESP;
          else                      beat_cnt_next = beat_cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign resp_code = err_reg ? RESP_SLVERR : RESP_OKAY;
  assign resp      = resp_valid ? resp_code : RESP_OKAY;
  assign resp_id   = resp_valid ? info_reg.id : 4'd0;
  assign busy      = (state_reg != ST_IDLE) || armed_reg;

  assign apb.psel    = apb_sel;
  assign apb.penable = apb_enable;
  assign apb.pwrite  = apb_sel;
  assign apb.paddr   = apb_sel ? cur_addr_reg : '0;
  assign apb.pwdata  = apb_sel ? fifo_head[FW-1:SW] : '0;
  assign apb.pstrb   = apb_sel ? fifo_head[SW-1:0] : '0;
  assign apb.pprot   = 3'b000;

  a_addr_only_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !(addr_info_valid && busy));
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(data_valid && !data_ready));

endmodule

// File: tb/tb_apb_write_engine.sv
// Directed bench for apb_write_engine: expected APB writes and burst responses
// are queued when stimulus is driven and compared as the DUT produces them.
module tb_apb_write_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_info_valid;
  logic [3:0]  addr_id;
  logic [31:0] addr;
  logic [3:0]  addr_len;
  logic [2:0]  addr_size;
  logic [1:0]  addr_burst;
  logic        data_valid;
  logic [31:0] data;
  logic [3:0]  data_strb;
  logic        data_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_id;
  logic [1:0]  resp;
  logic        busy;

  always #5 clk = ~clk;

  apb_write_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb();

  apb_write_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .addr_info_valid (addr_info_valid),
    .addr_id         (addr_id),
    .addr            (addr),
    .addr_len        (addr_len),
    .addr_size       (addr_size),
    .addr_burst      (addr_burst),
    .data_valid      (data_valid),
    .data            (data),
    .data_strb       (data_strb),
    .data_ready      (data_ready),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_id         (resp_id),
    .resp            (resp),
    .busy            (busy),
    .apb             (apb)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } apb_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] r;
  } resp_exp_t;

  apb_exp_t  apb_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int errors = 0;
  int apb_seen = 0;
  int psel_cycles = 0;
  int resp_seen = 0;
  int stall_beat = -1;
  int stall_len = 0;
  int err_beat = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // APB completer model plus scoreboard consumers, sampled on the falling edge.
  initial begin
    bit        prev_acc;
    int        wait_left;
    apb_exp_t  held, e;
    resp_exp_t r;
    prev_acc    = 1'b0;
    wait_left   = 0;
    apb.pready  = 1'b1;
    apb.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_acc    = 1'b0;
        apb.pready  = 1'b1;
        apb.pslverr = 1'b0;
      end else begin
        if (apb.psel) psel_cycles++;
        if (apb.psel && apb.penable) begin
          if (prev_acc) begin
            check("stall_paddr_stable", apb.paddr, held.a);
            check("stall_pwdata_stable", apb.pwdata, held.d);
            check("stall_pstrb_stable", apb.pstrb, held.s);
          end else begin
            held      = {apb.paddr, apb.pwdata, apb.pstrb};
            wait_left = (apb_seen == stall_beat) ? stall_len : 0;
          end
          if (wait_left > 0) begin
            apb.pready = 1'b0;
            wait_left--;
          end else begin
            apb.pready = 1'b1;
          end
          apb.pslverr = apb.pready && (apb_seen == err_beat);
          if (apb.pready) begin
            if (apb_q.size() == 0) begin
              check("apb_extra_write_qsize", 64'(apb_q.size()), 64'd1);
            end else begin
              e = apb_q.pop_front();
              check("apb_paddr", apb.paddr, e.a);
              check("apb_pwdata", apb.pwdata, e.d);
              check("apb_pstrb", apb.pstrb, e.s);
              check("apb_pwrite", apb.pwrite, 1'b1);
              check("apb_pprot", apb.pprot, 3'b000);
            end
            $display("APB write #%0d addr=%08h data=%08h strb=%h pslverr=%0b",
                     apb_seen, apb.paddr, apb.pwdata, apb.pstrb, apb.pslverr);
            apb_seen++;
          end
          prev_acc = !apb.pready;
        end else begin
          prev_acc    = 1'b0;
          apb.pready  = 1'b1;
          apb.pslverr = 1'b0;
        end
        if (resp_valid && resp_ready) begin
          if (resp_q.size() == 0) begin
            check("resp_extra_qsize", 64'(resp_q.size()), 64'd1);
          end else begin
            r = resp_q.pop_front();
            check("resp_id", resp_id, r.id);
            check("resp_code", resp, r.r);
          end
          $display("RESP id=%0h resp=%02b", resp_id, resp);
          resp_seen++;
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!data_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready_timeout", n < 500, 1'b1);
    data_valid = 1'b1;
    data       = d;
    data_strb  = s;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    addr_info_valid = 1'b1;
    addr_id         = id;
    addr            = a;
    addr_len        = len;
    addr_size       = size;
    addr_burst      = burst;
    @(posedge clk); #1;
    addr_info_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (resp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("resp_timeout", n < 3000, 1'b1);
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input bit beats_first, input int err_k, input int stall_k,
                           input int stall_n, input bit hold_resp, input int exp_psel);
    logic [31:0] bd [16];
    logic [3:0]  bs [16];
    logic [31:0] cur;
    bit          legal;
    int          psel_base;
    int          n;
    resp_exp_t   re;
    legal = (burst < 2'd2) && ((32'd1 << size) <= 32'd4);
    cur   = a;
    for (int i = 0; i <= int'(len); i++) begin
      bd[i] = $urandom;
      bs[i] = 4'($urandom_range(1, 15));
      if (legal) apb_q.push_back({cur, bd[i], bs[i]});
      if (burst == 2'b01) cur = cur + (32'd1 << size);
    end
    re.id = id;
    re.r  = (!legal || (err_k >= 0 && err_k <= int'(len))) ? 2'b10 : 2'b00;
    resp_q.push_back(re);
    err_beat   = (err_k >= 0) ? apb_seen + err_k : -1;
    stall_beat = (stall_k >= 0) ? apb_seen + stall_k : -1;
    stall_len  = stall_n;
    psel_base  = psel_cycles;
    $display("BURST id=%0h addr=%08h len=%0d size=%0d burst=%0d", id, a, len, size, burst);
    if (hold_resp) resp_ready = 1'b0;
    if (beats_first) begin
      for (int i = 0; i <= int'(len); i++) push_beat(bd[i], bs[i]);
      @(negedge clk);
      if (int'(len) >= 3) check("full_data_ready", data_ready, 1'b0);
      @(posedge clk); #1;
      send_addr(id, a, len, size, burst);
      @(negedge clk);
      check("lat_psel_cycle1", apb.psel, 1'b1);
      check("lat_penable_cycle1", apb.penable, 1'b0);
      @(negedge clk);
      check("lat_penable_cycle2", apb.penable, 1'b1);
      if (int'(len) >= 3) check("ready_before_pop", data_ready, 1'b0);
      @(negedge clk);
      check("ready_after_pop", data_ready, 1'b1);
      @(posedge clk); #1;
    end else begin
      send_addr(id, a, len, size, burst);
      for (int i = 0; i <= int'(len); i++) push_beat(bd[i], bs[i]);
    end
    if (hold_resp) begin
      n = 0;
      while (!resp_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("resp_wait_timeout", n < 500, 1'b1);
      repeat (3) begin
        check("resp_held_valid", resp_valid, 1'b1);
        check("resp_held_id", resp_id, id);
        check("resp_held_code", resp, re.r);
        @(negedge clk);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
    end
    wait_resp();
    check("busy_after_resp", busy, 1'b0);
    check("psel_cycle_count", 64'(psel_cycles - psel_base), 64'(exp_psel));
    check("apb_all_written", 64'(apb_q.size()), 64'd0);
    err_beat   = -1;
    stall_beat = -1;
    stall_len  = 0;
  endtask

  initial begin
    int n;
    int seen_base;
    int resp_base;
    int psel_base;
    logic [31:0] d;
    rst_n           = 1'b0;
    addr_info_valid = 1'b0;
    addr_id         = '0;
    addr            = '0;
    addr_len        = '0;
    addr_size       = '0;
    addr_burst      = '0;
    data_valid      = 1'b0;
    data            = '0;
    data_strb       = '0;
    resp_ready      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_psel", apb.psel, 1'b0);
    check("rst_penable", apb.penable, 1'b0);
    check("rst_paddr", apb.paddr, 32'h0);
    check("rst_data_ready", data_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // id, addr, len, size, burst, beats_first, err_k, stall_k, stall_n, hold_resp, exp_psel
    run_burst(4'h5, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 1'b0, -1, -1, 0, 1'b1, 8);
    run_burst(4'h3, 32'h0000_0040, 4'd1, 3'd2, 2'b00, 1'b0, -1,  0, 3, 1'b0, 7);
    run_burst(4'h9, 32'h0000_0200, 4'd2, 3'd2, 2'b01, 1'b0,  1, -1, 0, 1'b0, 6);
    run_burst(4'hA, 32'h0000_0300, 4'd3, 3'd2, 2'b10, 1'b0, -1, -1, 0, 1'b0, 0);
    run_burst(4'hB, 32'h0000_0380, 4'd1, 3'd3, 2'b01, 1'b0, -1, -1, 0, 1'b0, 0);
    run_burst(4'h6, 32'h0000_0500, 4'd3, 3'd2, 2'b01, 1'b1, -1, -1, 0, 1'b0, 8);
    run_burst(4'h7, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 1'b0, -1, -1, 0, 1'b0, 4);

    // Reset while beat 1 sits in its ACCESS phase: burst abandoned, no response.
    seen_base  = apb_seen;
    resp_base  = resp_seen;
    stall_beat = apb_seen + 1;
    stall_len  = 1000;
    d = $urandom;
    apb_q.push_back({32'h0000_0600, d, 4'hF});
    push_beat(d, 4'hF);
    for (int i = 1; i < 4; i++) push_beat($urandom, 4'hF);
    send_addr(4'hC, 32'h0000_0600, 4'd3, 3'd2, 2'b01);
    n = 0;
    while (!(apb_seen == seen_base + 1 && apb.psel && apb.penable) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reset_test_reach_access", n < 200, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_psel", apb.psel, 1'b0);
    check("midrst_penable", apb.penable, 1'b0);
    check("midrst_data_ready", data_ready, 1'b1);
    check("midrst_resp_valid", resp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    stall_beat = -1;
    stall_len  = 0;
    psel_base  = psel_cycles;
    repeat (20) @(posedge clk);
    #1;
    check("postrst_no_resp", 64'(resp_seen - resp_base), 64'd0);
    check("postrst_resp_valid", resp_valid, 1'b0);
    check("postrst_no_apb", 64'(psel_cycles - psel_base), 64'd0);
    check("postrst_data_ready", data_ready, 1'b1);
    check("postrst_busy", busy, 1'b0);
    check("postrst_apb_q", 64'(apb_q.size()), 64'd0);

    run_burst(4'hD, 32'h0000_0700, 4'd0, 3'd2, 2'b01, 1'b0, -1, -1, 0, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
